// File: rtl/int2float_share_ctrl_if.sv
// Handshake bundle between the requesting stages and the shared int-to-float controller:
// per-requester operand channels plus a single tagged response channel.
interface int2float_share_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int IN_W    = 11,
    parameter int OUT_W   = 7
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*IN_W-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    rsp_valid;
    logic [OUT_W-1:0]        rsp_data;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_ready;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/int2float_share_ctrl.sv
// Round-robin sequencer sharing one combinational int-to-float converter among NUM_REQ
// requesters; operands are registered onto conv_x and results returned with the owner's ID.
module int2float_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int IN_W    = 11,
    parameter int OUT_W   = 7,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    int2float_share_ctrl_if.slave bus,
    output logic [IN_W-1:0]      conv_x,
    input  logic [OUT_W-1:0]     conv_y,
    output logic                 busy,
    output logic [CNT_W-1:0]     conv_cnt
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [IN_W-1:0]   op_q, op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [OUT_W-1:0]  rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;

    logic [ID_W-1:0]    grant_id_s;
    logic               grant_any_s;
    logic [ID_W:0]      idx_s;
    logic               slot_open_s;
    logic               accept_s;
    logic [NUM_REQ-1:0] req_ready_s;

    // Round-robin search: walk from the farthest candidate back so the one nearest rr_ptr wins.
    always_comb begin
        grant_id_s  = '0;
        grant_any_s = 1'b0;
        idx_s       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_s = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (idx_s >= (ID_W+1)'(NUM_REQ)) begin
                idx_s = idx_s - (ID_W+1)'(NUM_REQ);
            end else begin
                idx_s = idx_s;
            end
            if (bus.req_valid[idx_s[ID_W-1:0]]) begin
                grant_id_s  = idx_s[ID_W-1:0];
                grant_any_s = 1'b1;
            end else begin
                grant_id_s  = grant_id_s;
                grant_any_s = grant_any_s;
            end
        end
    end

    // Accept slot and one-hot ready; ready is gated by reset and never looks at req_data.
    always_comb begin
        slot_open_s = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
        accept_s    = rst_n && slot_open_s && grant_any_s;
        if (accept_s) begin
            req_ready_s = NUM_REQ'(1'b1) << grant_id_s;
        end else begin
            req_ready_s = '0;
        end
    end

    // Next-state for the FSM and all datapath registers.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            CONV: begin
                rsp_data_d  = conv_y;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    cnt_d       = cnt_q + CNT_W'(1'b1);
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
        // An accept always launches a conversion, also when it coincides with a response handshake.
        if (accept_s) begin
            op_d    = bus.req_data[grant_id_s*IN_W +: IN_W];
            id_d    = grant_id_s;
            state_d = CONV;
            if (grant_id_s == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_id_s + ID_W'(1'b1);
            end
        end else begin
            rr_ptr_d = rr_ptr_d;
        end
        busy_d = (state_d != IDLE);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign conv_x        = op_q;
    assign busy          = busy_q;
    assign conv_cnt      = cnt_q;
endmodule

// File: tb/tb_int2float_share_ctrl.sv
// Bench for int2float_share_ctrl: a transaction-level model checked every cycle, directed
// scenarios pinned with literal expectations, then randomized traffic with random resets.
module tb_int2float_share_ctrl;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int IN_W    = 11;
    localparam int OUT_W   = 7;
    localparam int CNT_W   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int2float_share_ctrl_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();
    logic [IN_W-1:0]  conv_x;
    logic [OUT_W-1:0] conv_y;
    logic             busy;
    logic [CNT_W-1:0] conv_cnt;

    assign conv_y = conv_x[OUT_W-1:0];

    int2float_share_ctrl #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .conv_x(conv_x), .conv_y(conv_y), .busy(busy), .conv_cnt(conv_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int ncyc   = 0;

    // Model: a conversion in flight (one cycle), a held response, the last operand, pointer, count.
    bit               m_init = 1'b0;
    bit               m_conv = 1'b0;
    bit               m_rv   = 1'b0;
    logic [OUT_W-1:0] m_rd   = '0;
    int               m_rid  = 0;
    logic [IN_W-1:0]  m_op   = '0;
    int               m_ptr  = 0;
    int               m_pid  = 0;
    int               m_cnt  = 0;

    int grant_q[$];
    int grant_cyc[$];
    int rsp_id_log[$];
    int rsp_dat_log[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic int winner();
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (bus.req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] exp_ready();
        int g;
        bit open;
        g    = winner();
        open = (!m_conv && !m_rv) || (m_rv && bus.rsp_ready);
        if (rst_n && open && g >= 0) return NUM_REQ'(1) << g;
        return '0;
    endfunction

    task automatic model_step();
        int g;
        logic [NUM_REQ-1:0] rdy;
        if (!rst_n) begin
            m_conv = 1'b0; m_rv = 1'b0; m_rd = '0; m_rid = 0;
            m_op = '0; m_ptr = 0; m_pid = 0; m_cnt = 0;
            m_init = 1'b1;
        end else if (m_init) begin
            rdy = exp_ready();
            g   = winner();
            if (m_conv) begin
                m_rv   = 1'b1;
                m_rd   = m_op[OUT_W-1:0];
                m_rid  = m_pid;
                m_conv = 1'b0;
            end else if (m_rv && bus.rsp_ready) begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
                m_rv  = 1'b0;
            end
            if (rdy != '0) begin
                m_op   = bus.req_data[g*IN_W +: IN_W];
                m_pid  = g;
                m_ptr  = (g + 1) % NUM_REQ;
                m_conv = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison against the model, plus logging of grants and responses.
    always @(negedge clk) begin
        ncyc++;
        if (m_init) begin
            chk("req_ready", bus.req_ready, exp_ready());
            chk("rsp_valid", bus.rsp_valid, m_rv);
            chk("busy", busy, m_conv || m_rv);
            chk("conv_x", conv_x, m_op);
            chk("conv_cnt", conv_cnt, m_cnt);
            if (m_rv) begin
                chk("rsp_data", bus.rsp_data, m_rd);
                chk("rsp_id", bus.rsp_id, m_rid);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready[i] && bus.req_valid[i]) begin
                grant_q.push_back(i);
                grant_cyc.push_back(ncyc);
            end
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_id_log.push_back(int'(bus.rsp_id));
            rsp_dat_log.push_back(int'(bus.rsp_data));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_data_base();
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*IN_W +: IN_W] = 11'h010 + IN_W'(i);
    endtask

    initial begin
        int exp_g[5];
        logic [CNT_W-1:0] wrap_exp[3];
        exp_g    = '{0, 1, 2, 3, 0};
        wrap_exp = '{4'd15, 4'd0, 4'd1};
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        settle();
        chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
        chk("reset_conv_x", conv_x, 11'h000);
        chk("reset_cnt", conv_cnt, 4'd0);

        // Single request from requester 2.
        bus.req_data[2*IN_W +: IN_W] = 11'h155;
        bus.req_valid = 4'b0100;
        settle();
        chk("single_ready", bus.req_ready, 4'b0100);
        step();
        bus.req_valid = 4'b0000;
        step();
        settle();
        chk("single_rsp_valid", bus.rsp_valid, 1'b1);
        chk("single_rsp_data", bus.rsp_data, 7'h55);
        chk("single_rsp_id", bus.rsp_id, 2'd2);
        bus.rsp_ready = 1'b1;
        step();
        settle();
        chk("single_done_valid", bus.rsp_valid, 1'b0);
        chk("single_cnt", conv_cnt, 4'd1);
        bus.rsp_ready = 1'b0;

        // Fairness with all requesters active and a always-ready consumer.
        do_reset();
        grant_q.delete(); grant_cyc.delete(); rsp_id_log.delete(); rsp_dat_log.delete();
        set_data_base();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        repeat (10) step();
        bus.req_valid = 4'b0000;
        repeat (4) step();
        chk("fair_grant_count", grant_q.size() >= 5, 1'b1);
        if (grant_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("fair_grant", grant_q[i], exp_g[i]);
                if (i > 0) chk("fair_spacing", grant_cyc[i] - grant_cyc[i-1], 2);
            end
        end
        chk("fair_rsp_count", rsp_id_log.size() >= 4, 1'b1);
        if (rsp_id_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("fair_rsp_id", rsp_id_log[i], i);
                chk("fair_rsp_data", rsp_dat_log[i], 32'h10 + i);
            end
        end

        // Backpressure: response held while others keep requesting.
        do_reset();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1111;
        step();
        step();
        settle();
        chk("bp_valid", bus.rsp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            settle();
            chk("bp_data_hold", bus.rsp_data, 7'h10);
            chk("bp_id_hold", bus.rsp_id, 2'd0);
            chk("bp_ready_low", bus.req_ready, 4'b0000);
            chk("bp_cnt_hold", conv_cnt, 4'd0);
        end
        bus.rsp_ready = 1'b1;
        settle();
        chk("bp_release_ready", bus.req_ready, 4'b0010);
        step();
        settle();
        chk("bp_cnt", conv_cnt, 4'd1);
        bus.req_valid = 4'b0000;
        repeat (3) step();

        // Pointer: after a grant to 2, contest 4'b1001 goes to 3, then to 0.
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b0000;
        repeat (3) step();
        settle();
        chk("ptr_idle", busy, 1'b0);
        bus.req_valid = 4'b1001;
        settle();
        chk("ptr_grant3", bus.req_ready, 4'b1000);
        step();
        step();
        settle();
        chk("ptr_grant0", bus.req_ready, 4'b0001);
        step();
        bus.req_valid = 4'b0000;
        repeat (3) step();

        // Reset while a conversion is in flight; pointer must restart from 0.
        bus.req_valid = 4'b0110;
        settle();
        chk("rst_pre_grant", bus.req_ready, 4'b0010);
        step();
        rst_n = 1'b0;
        settle();
        chk("rst_low_ready", bus.req_ready, 4'b0000);
        step();
        settle();
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_conv_x", conv_x, 11'h000);
        chk("rst_cnt", conv_cnt, 4'd0);
        rst_n = 1'b1;
        settle();
        chk("rst_regrant", bus.req_ready, 4'b0010);
        step();
        bus.req_valid = 4'b0000;
        repeat (3) step();

        // Counter wrap over 17 responses.
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b1111;
        for (int n = 1; n <= 17; n++) begin
            int t;
            t = 0;
            while (!bus.rsp_valid && t < 10) begin
                step();
                settle();
                t++;
            end
            chk("wrap_rsp_seen", bus.rsp_valid, 1'b1);
            step();
            settle();
            if (n >= 15) chk("wrap_cnt", conv_cnt, wrap_exp[n-15]);
        end
        bus.req_valid = 4'b0000;
        repeat (3) step();

        // Randomized traffic, random backpressure and occasional reset.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [NUM_REQ-1:0] nv;
            nv = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!bus.req_valid[i]) bus.req_data[i*IN_W +: IN_W] = IN_W'($urandom);
            end
            bus.req_valid = nv;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            rst_n         = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/int2float_share_ctrl.md
Name: int2float_share_ctrl

Overview:
- Sequencer and round-robin arbiter that shares one instance of the combinational 11-bit-integer to 7-bit-float converter between NUM_REQ requesters.
- Accepts operands over per-requester valid/ready handshakes and registers each operand onto the converter inputs.
- Captures the converter outputs one cycle later and returns them over a single valid/ready response channel, tagged with the requester ID.
- Sits between the requesting pipeline stages and the converter instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal ceil(log2(NUM_REQ)).
- IN_W, 11, converter input width.
- OUT_W, 7, converter output width.
- CNT_W, 16, width of the completed-conversion counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*IN_W  operands; requester i occupies bits [i*IN_W +: IN_W].
- req_ready  out  NUM_REQ  one-hot grant/accept; combinational.
- conv_x  out  IN_W  operand to converter; driven directly from op_reg.
- conv_y  in  OUT_W  converter result; combinational function of conv_x.
- rsp_valid  out  1  response valid.
- rsp_data  out  OUT_W  registered converter result.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_ready  in  1  response consumer ready.
- busy  out  1  high whenever state != IDLE.
- conv_cnt  out  CNT_W  completed-response count; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low at a clock edge) forces the following values:
  - state=IDLE, rr_ptr=0
  - op_reg=0, so conv_x=0
  - rsp_valid=0, rsp_data=0, rsp_id=0
  - conv_cnt=0
- Reset overrides every other event. A conversion or held response in flight when reset asserts is discarded and no handshake completes in that cycle.
- While rst_n is low, req_ready is 0.
- Arbitration is round-robin:
  - The winner g is the first index with req_valid high, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g] is high only when an accept slot is open (below). All other req_ready bits are 0.
  - req_ready never depends on req_data.
- An accept slot is open when state==IDLE, or when state==RESP and rsp_ready==1.
- Accept: req_valid[g] and req_ready[g] both high at an edge. On that edge:
  - op_reg <= req_data[g]
  - id_reg <= g
  - rr_ptr <= (g+1) mod NUM_REQ
  - state <= CONV
- rr_ptr changes only on an accept.
- FSM:
  - IDLE: when any req_valid is high, accept and go to CONV; otherwise stay.
  - CONV (exactly 1 cycle; conv_x=op_reg settles through the converter): at the edge, rsp_data <= conv_y, rsp_id <= id_reg, rsp_valid <= 1, state <= RESP. No req_ready is asserted in CONV.
  - RESP: rsp_valid=1. rsp_data and rsp_id are held stable while rsp_ready=0.
    - Response handshake (rsp_ready=1): conv_cnt increments, wrapping from 2^CNT_W-1 to 0.
    - If an accept also occurs in the same cycle, go to CONV with rsp_valid <= 0.
    - Otherwise go to IDLE with rsp_valid <= 0.
- Timing:
  - Latency from accept edge to rsp_valid high: 2 edges.
  - Minimum accept-to-accept spacing: 2 cycles (back-to-back via RESP).
- op_reg holds its value outside accept edges, so conv_x is stable except immediately after an accept.
- req_valid dropping without a handshake has no effect. Requesters must hold req_data stable while req_valid is high.
- busy = (state != IDLE).

Test Plan:
- Bench ties conv_y = conv_x[6:0] as a stub so routing is observable.
- Single request: reset, then req_valid=4'b0100 with requester 2 data 11'h155.
  - req_ready=4'b0100 the same cycle.
  - Two edges later: rsp_valid=1, rsp_data=7'h55, rsp_id=2.
  - Then rsp_ready=1 gives rsp_valid=0 next cycle and conv_cnt=1.
- Fairness: all four req_valid held high, rsp_ready=1 throughout, data i = 11'h010+i.
  - Grant order 0,1,2,3,0.
  - rsp_id sequence 0,1,2,3 with rsp_data 7'h10..7'h13.
  - One accept every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises.
  - rsp_data and rsp_id stay constant.
  - req_ready=0 throughout despite other req_valid high.
  - conv_cnt unchanged until rsp_ready=1.
- Pointer: rr_ptr=3 after a requester-2 grant, then req_valid=4'b1001 → grant 3; next contest with 4'b1001 → grant 0.
- Reset mid-operation: assert rst_n=0 in the CONV cycle.
  - Next cycle: rsp_valid=0, busy=0, conv_x=0, conv_cnt=0.
  - The pending request is re-granted only after rst_n=1, starting from requester 0.
- Counter wrap: with CNT_W=4, complete 17 responses → conv_cnt reads 15, then 0, then 1.
